// File: rtl/nway_cache_if.sv
// Bus bundle for nway_cache: CPU request/response, backing-memory transfer
// and the performance counters. The slave modport is the cache itself; the
// master modport is the surrounding system (CPU plus physical memory).
interface nway_cache_if;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [31:0]  mem_byte_enable256;
    logic [255:0] mem_wdata256;
    logic [255:0] mem_rdata256;
    logic         mem_resp;

    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    modport slave (
        input  mem_read, mem_write, mem_address, mem_byte_enable256, mem_wdata256,
        output mem_rdata256, mem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp,
        output hit_count, miss_count
    );

    modport master (
        output mem_read, mem_write, mem_address, mem_byte_enable256, mem_wdata256,
        input  mem_rdata256, mem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp,
        input  hit_count, miss_count
    );
endinterface

// File: rtl/nway_cache.sv
// N-way set-associative write-back cache with tree pseudo-LRU replacement.
// Optional hit/miss performance counters are built only when the macro
// CACHE_PERF_CNT_EN is defined; otherwise both counters read as zero.
//
// state     | meaning
// IDLE      | waiting for a CPU request
// CHECK     | tag compare; hit answers the CPU, miss picks a victim
// WRITEBACK | dirty victim line being written to memory
// FILL      | requested line being read from memory into the victim way
module nway_cache #(
    parameter int s_offset = 5,
    parameter int s_index  = 3,
    parameter int ways     = 4
) (
    input logic         clk,
    input logic         rst,
    nway_cache_if.slave bus
);
    localparam int num_sets = 2 ** s_index;
    localparam int s_tag    = 32 - s_offset - s_index;
    localparam int s_way    = $clog2(ways);

    typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, FILL} state_t;
    state_t state, state_next;

    logic [ways-1:0]  valid   [num_sets];
    logic [ways-1:0]  dirty   [num_sets];
    logic [ways-2:0]  plru    [num_sets];
    logic [s_tag-1:0] tag_arr [num_sets][ways];
    logic [255:0]     data_arr[num_sets][ways];

    logic [s_way-1:0] victim_q;
    // Set when CHECK is re-entered after a fill, so that the closing hit of a
    // miss is not also counted as a hit.
    logic             from_fill;

    logic [s_index-1:0] idx;
    logic [s_tag-1:0]   req_tag;
    logic               req;
    logic               hit;
    logic [s_way-1:0]   hit_way;
    logic [s_way-1:0]   victim;
    logic [ways-2:0]    plru_touch;

    assign idx     = bus.mem_address[s_offset +: s_index];
    assign req_tag = bus.mem_address[31 -: s_tag];
    assign req     = bus.mem_read | bus.mem_write;

    // Tag compare across all ways of the addressed set.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < ways; w++) begin
            if (valid[idx][w] && (tag_arr[idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = s_way'(w);
            end
        end
    end

    // Victim choice: lowest invalid way, else walk the PLRU tree (bit = direction of victim).
    always_comb begin : victim_sel
        int   node;
        logic b;
        victim = '0;
        node   = 1;
        for (int l = 0; l < s_way; l++) begin
            b                    = plru[idx][node-1];
            victim[s_way-1-l]    = b;
            node                 = 2 * node + int'(b);
        end
        for (int w = ways - 1; w >= 0; w--) begin
            if (!valid[idx][w]) victim = s_way'(w);
        end
    end

    // PLRU value after touching the hit way: every node on its path points away from it.
    always_comb begin : plru_upd
        int   node;
        logic b;
        plru_touch = plru[idx];
        node       = 1;
        for (int l = 0; l < s_way; l++) begin
            b                  = hit_way[s_way-1-l];
            plru_touch[node-1] = ~b;
            node               = 2 * node + int'(b);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      if (req) state_next = CHECK;
            CHECK: begin
                if (!req || hit)         state_next = IDLE;
                else if (dirty[idx][victim]) state_next = WRITEBACK;
                else                     state_next = FILL;
            end
            WRITEBACK: if (bus.pmem_resp) state_next = FILL;
            FILL:      if (bus.pmem_resp) state_next = CHECK;
            default:   state_next = IDLE;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        bus.mem_resp     = (state == CHECK) && req && hit;
        bus.mem_rdata256 = data_arr[idx][hit_way];
        bus.pmem_read    = (state == FILL);
        bus.pmem_write   = (state == WRITEBACK);
        bus.pmem_wdata   = data_arr[idx][victim_q];
        bus.pmem_address = {bus.mem_address[31:s_offset], {s_offset{1'b0}}};
        if (state == WRITEBACK)
            bus.pmem_address = {tag_arr[idx][victim_q], idx, {s_offset{1'b0}}};
    end

    // Valid/dirty/PLRU bookkeeping and miss victim latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < num_sets; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                plru[s]  <= '0;
            end
            victim_q  <= '0;
            from_fill <= 1'b0;
        end else begin
            if (bus.mem_resp) begin
                plru[idx] <= plru_touch;
                if (bus.mem_write) dirty[idx][hit_way] <= 1'b1;
                from_fill <= 1'b0;
            end else if (state == CHECK && req) begin
                victim_q <= victim;
            end
            if (state == FILL && bus.pmem_resp) begin
                valid[idx][victim_q] <= 1'b1;
                dirty[idx][victim_q] <= 1'b0;
                from_fill            <= 1'b1;
            end
        end
    end

    // Line and tag storage; a fill writes the whole line, a write hit merges enabled bytes.
    always_ff @(posedge clk) begin
        if (state == FILL && bus.pmem_resp) begin
            data_arr[idx][victim_q] <= bus.pmem_rdata;
            tag_arr[idx][victim_q]  <= req_tag;
        end else if (bus.mem_resp && bus.mem_write) begin
            for (int b = 0; b < 32; b++) begin
                if (bus.mem_byte_enable256[b])
                    data_arr[idx][hit_way][8*b +: 8] <= bus.mem_wdata256[8*b +: 8];
            end
        end
    end

`ifdef CACHE_PERF_CNT_EN
    logic [31:0] hit_q, miss_q;

    // Saturating hit/miss counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (bus.mem_resp && !from_fill && hit_q != 32'hFFFF_FFFF)
                hit_q <= hit_q + 32'd1;
            if (state == CHECK && req && !hit && miss_q != 32'hFFFF_FFFF)
                miss_q <= miss_q + 32'd1;
        end
    end

    assign bus.hit_count  = hit_q;
    assign bus.miss_count = miss_q;
`else
    assign bus.hit_count  = 32'd0;
    assign bus.miss_count = 32'd0;
`endif
endmodule

// File: tb/tb_nway_cache.sv
// Self-checking bench for nway_cache: directed scenarios then random traffic,
// compared against a flat byte-addressable memory plus a tag/PLRU model.
module tb_nway_cache;
    localparam int WAYS = 4;
    localparam int SETS = 8;
    localparam int LG   = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nway_cache_if bus();
    nway_cache #(.s_offset(5), .s_index(3), .ways(WAYS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    logic [255:0] pmem    [int unsigned];
    logic [255:0] ref_mem [int unsigned];
    int           fill_cnt = 0;
    int           wb_cnt   = 0;
    logic [31:0]  wb_q[$];
    bit           hold_resp = 0;
    int           viol = 0;
    logic [255:0] last_rdata;

    bit          m_valid[SETS][WAYS];
    bit          m_dirty[SETS][WAYS];
    int          m_tag  [SETS][WAYS];
    bit          m_plru [SETS][WAYS-1];
    logic [31:0] exp_hit  = 0;
    logic [31:0] exp_miss = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] init_line(int unsigned ln);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = (ln * 32'h9E37_79B1) ^ (k * 32'h0101_0101);
        return l;
    endfunction

    function automatic logic [255:0] pmem_line(int unsigned ln);
        return pmem.exists(ln) ? pmem[ln] : init_line(ln);
    endfunction

    function automatic logic [255:0] ref_line(int unsigned ln);
        return ref_mem.exists(ln) ? ref_mem[ln] : init_line(ln);
    endfunction

    function automatic int plru_victim(int s);
        int n = 0;
        int w = 0;
        for (int l = 0; l < LG; l++) begin
            int b = int'(m_plru[s][n]);
            w = w * 2 + b;
            n = 2 * n + 1 + b;
        end
        return w;
    endfunction

    function automatic void plru_touch(int s, int w);
        int n = 0;
        for (int l = 0; l < LG; l++) begin
            int b = (w >> (LG - 1 - l)) & 1;
            m_plru[s][n] = (b == 0);
            n = 2 * n + 1 + b;
        end
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
            end
            for (int n = 0; n < WAYS - 1; n++) m_plru[s][n] = 0;
        end
        exp_hit  = 0;
        exp_miss = 0;
        ref_mem  = pmem;
    endfunction

    // Physical memory: answers after a random 0..3 cycle delay.
    initial begin
        int dly;
        dly = -1;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.pmem_resp = 1'b0;
            if (rst || hold_resp) begin
                dly = -1;
            end else if (bus.pmem_read || bus.pmem_write) begin
                if (dly < 0) dly = int'($urandom_range(0, 3));
                if (dly == 0) begin
                    if (bus.pmem_write) begin
                        pmem[bus.pmem_address >> 5] = bus.pmem_wdata;
                        wb_q.push_back(bus.pmem_address);
                        wb_cnt++;
                    end else begin
                        bus.pmem_rdata = pmem_line(bus.pmem_address >> 5);
                        fill_cnt++;
                    end
                    bus.pmem_resp = 1'b1;
                    dly = -1;
                end else begin
                    dly--;
                end
            end
        end
    end

    // Protocol watch: exclusive pmem strobes, no response without a request.
    always @(negedge clk) begin
        if (bus.pmem_read && bus.pmem_write) viol++;
        if (bus.mem_resp && !(bus.mem_read || bus.mem_write)) viol++;
    end

    task automatic do_op(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] be, input logic [255:0] wd, input string tag);
        int           ln, set, t, way, f0, w0, cyc;
        bit           hit, exp_wbf;
        logic [31:0]  exp_wb;
        logic [255:0] exp_rd, line;
        ln  = int'(addr >> 5);
        set = ln % SETS;
        t   = ln / SETS;
        hit = 0;
        way = -1;
        exp_wbf = 0;
        exp_wb  = '0;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[set][w] && m_tag[set][w] == t) begin hit = 1; way = w; end
        if (!hit) begin
            for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[set][w]) way = w;
            if (way < 0) way = plru_victim(set);
            if (m_dirty[set][way]) begin
                exp_wbf = 1;
                exp_wb  = 32'((m_tag[set][way] * SETS + set) << 5);
            end
            m_valid[set][way] = 1;
            m_tag[set][way]   = t;
            m_dirty[set][way] = 0;
`ifdef CACHE_PERF_CNT_EN
            exp_miss++;
`endif
        end else begin
`ifdef CACHE_PERF_CNT_EN
            exp_hit++;
`endif
        end
        plru_touch(set, way);
        exp_rd = ref_line(ln);
        if (wr) begin
            m_dirty[set][way] = 1;
            line = exp_rd;
            for (int b = 0; b < 32; b++) if (be[b]) line[8*b +: 8] = wd[8*b +: 8];
            ref_mem[ln] = line;
        end

        @(negedge clk);
        bus.mem_read           = rd;
        bus.mem_write          = wr;
        bus.mem_address        = addr;
        bus.mem_byte_enable256 = be;
        bus.mem_wdata256       = wd;
        f0  = fill_cnt;
        w0  = wb_cnt;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!bus.mem_resp && cyc < 100);
        if (!bus.mem_resp) begin
            check({tag, "_timeout"}, 256'(0), 256'(1));
            bus.mem_read  = 0;
            bus.mem_write = 0;
            return;
        end
        last_rdata = bus.mem_rdata256;
        if (rd && !wr) check({tag, "_rdata"}, bus.mem_rdata256, exp_rd);
        if (hit) check({tag, "_hit_latency"}, 256'(cyc), 256'(1));
        check({tag, "_fills"}, 256'(fill_cnt - f0), 256'(hit ? 0 : 1));
        check({tag, "_writebacks"}, 256'(wb_cnt - w0), 256'(exp_wbf));
        if (exp_wbf) check({tag, "_wb_addr"}, 256'(wb_q[$]), 256'(exp_wb));
        @(posedge clk);
        #1;
        bus.mem_read  = 0;
        bus.mem_write = 0;
        check({tag, "_hit_count"}, 256'(bus.hit_count), 256'(exp_hit));
        check({tag, "_miss_count"}, 256'(bus.miss_count), 256'(exp_miss));
    endtask

    initial begin
        int           cyc, w0;
        bit           found;
        logic [255:0] exp_line, wd;
        logic [31:0]  a;

        rst                    = 1'b1;
        bus.mem_read           = 0;
        bus.mem_write          = 0;
        bus.mem_address        = '0;
        bus.mem_byte_enable256 = '0;
        bus.mem_wdata256       = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_resp", 256'(bus.mem_resp), 256'(0));
        check("rst_pmem_read", 256'(bus.pmem_read), 256'(0));
        check("rst_pmem_write", 256'(bus.pmem_write), 256'(0));
        check("rst_hit_count", 256'(bus.hit_count), 256'(0));
        check("rst_miss_count", 256'(bus.miss_count), 256'(0));
        @(negedge clk);
        rst = 1'b0;

        do_op(1, 0, 32'h40, '0, '0, "rd40_miss");
        check("rd40_line_a", last_rdata, init_line(2));
        do_op(1, 0, 32'h40, '0, '0, "rd40_hit");
        do_op(0, 1, 32'h40, 32'h0000_000F, {32{8'hAA}}, "wr40");
        do_op(1, 0, 32'h40, '0, '0, "rd40_merged");
        exp_line        = init_line(2);
        exp_line[31:0]  = 32'hAAAA_AAAA;
        check("rd40_merge_bytes", last_rdata, exp_line);

        w0 = wb_cnt;
        for (int i = 1; i <= 4; i++) do_op(1, 0, 32'((i << 8) | 32'h40), '0, '0, "set2_fill");
        check("set2_wb_count", 256'(wb_cnt - w0), 256'(1));
        check("set2_wb_addr", 256'(wb_q[$]), 256'(32'h40));

        for (int k = 0; k < 8; k++) wd[32*k +: 32] = $urandom;
        do_op(1, 1, 32'h100, 32'hFFFF_FFFF, wd, "rdwr100");
        w0 = wb_cnt;
        for (int i = 2; i <= 5; i++) do_op(1, 0, 32'(i << 8), '0, '0, "set0_evict");
        found = 0;
        for (int i = w0; i < wb_cnt; i++) if (wb_q[i] == 32'h100) found = 1;
        check("rdwr100_dirty_wb", 256'(found), 256'(1));
        do_op(1, 0, 32'h100, '0, '0, "rd100_back");
        check("rd100_written", last_rdata, wd);

        hold_resp = 1;
        @(negedge clk);
        bus.mem_read    = 1;
        bus.mem_address = 32'h0000_0A00;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!bus.pmem_read && cyc < 20);
        check("midfill_pmem_read_seen", 256'(bus.pmem_read), 256'(1));
        #2;
        rst = 1'b1;
        #1;
        check("midfill_rst_pmem_read", 256'(bus.pmem_read), 256'(0));
        check("midfill_rst_mem_resp", 256'(bus.mem_resp), 256'(0));
        @(negedge clk);
        bus.mem_read = 0;
        rst          = 1'b0;
        hold_resp    = 0;
        model_reset();
        check("midfill_hit_count", 256'(bus.hit_count), 256'(0));
        check("midfill_miss_count", 256'(bus.miss_count), 256'(0));
        do_op(1, 0, 32'h0000_0A00, '0, '0, "rd_after_rst");

        repeat (150) begin
            int kind;
            kind = int'($urandom_range(0, 2));
            a    = 32'(($urandom_range(0, 5) << 8) | ($urandom_range(0, 7) << 5) | $urandom_range(0, 31));
            for (int k = 0; k < 8; k++) wd[32*k +: 32] = $urandom;
            do_op(kind != 1, kind != 0, a, $urandom, wd, "rand");
        end

        check("protocol_violations", 256'(viol), 256'(0));
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
